// File: rtl/gray_hazard_scanner_if.sv
// Bus between the test sequencer / block under test (master) and the hazard scanner (slave).
interface gray_hazard_scanner_if #(
  parameter int unsigned M = 3,
  parameter int unsigned C = 1
);
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

  logic          start;
  logic [M-1:0]  dutIn;
  logic [C-1:0]  dutOut;
  logic          busy;
  logic          done;
  logic          hazard;
  logic [C-1:0]  hazardMask;
  logic [M:0]    firstStep;
  logic [CW-1:0] firstChan;

  modport master (
    output start, dutOut,
    input  dutIn, busy, done, hazard, hazardMask, firstStep, firstChan
  );

  modport slave (
    input  start, dutOut,
    output dutIn, busy, done, hazard, hazardMask, firstStep, firstChan
  );
endinterface

// File: rtl/gray_hazard_scanner.sv
// Gray-code up/down stimulus walk with per-channel oversampled glitch detection.
// Optional HAZARD_SYNC_EN adds a 2-flop synchronizer ahead of the sample register.
module gray_hazard_scanner #(
  parameter int unsigned M    = 3,
  parameter int unsigned C    = 1,
  parameter int unsigned HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gray_hazard_scanner_if.slave  bus_if
);
  localparam int unsigned N  = 1 << M;
  localparam int unsigned S  = 2 * N - 1;
  localparam int unsigned SW = M + 1;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned HW = 8;
`ifdef HAZARD_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t        state_q;
  logic [HW-1:0] hold_q;
  logic [SW-1:0] step_q;
  logic [M-1:0]  dut_in_q;
  logic          busy_q;
  logic          done_q;
  logic          hazard_q;
  logic [C-1:0]  mask_q;
  logic [SW-1:0] first_step_q;
  logic [CW-1:0] first_chan_q;

  // Data and step tags travel together so each sample knows its window.
  logic [C-1:0]  samp_q      [LAT];
  logic          tag_vld_q   [LAT];
  logic          tag_first_q [LAT];
  logic [SW-1:0] tag_step_q  [LAT];
  logic [C-1:0]  prev_q;
  logic [1:0]    edge_cnt_q  [C];
  logic [1:0]    edge_cnt_d  [C];

  logic [C-1:0]  sample_c;
  logic [C-1:0]  hit_c;
  logic          any_hit_c;
  logic [CW-1:0] hit_chan_c;
  logic [SW-1:0] step_nxt_c;
  logic [M-1:0]  idx_nxt_c;
  logic [M-1:0]  code_nxt_c;

  // Per-channel saturating edge count within the current window.
  always_comb begin
    sample_c   = samp_q[LAT-1];
    hit_c      = '0;
    hit_chan_c = '0;
    for (int c = 0; c < int'(C); c++) begin
      edge_cnt_d[c] = edge_cnt_q[c];
      if (tag_vld_q[LAT-1]) begin
        if (tag_first_q[LAT-1]) edge_cnt_d[c] = 2'd0;
        if ((sample_c[c] != prev_q[c]) && (edge_cnt_d[c] != 2'd3))
          edge_cnt_d[c] = edge_cnt_d[c] + 2'd1;
        hit_c[c] = edge_cnt_d[c][1];
      end
    end
    for (int c = int'(C) - 1; c >= 0; c--) begin
      if (hit_c[c]) hit_chan_c = CW'(c);
    end
    any_hit_c = |hit_c;
  end

  // Next code: ascend through g(0..N-1), then fold back down to g(0).
  always_comb begin
    step_nxt_c = step_q + SW'(1);
    if (step_nxt_c < SW'(N)) idx_nxt_c = step_nxt_c[M-1:0];
    else                     idx_nxt_c = M'(SW'(2 * N - 2) - step_nxt_c);
    code_nxt_c = idx_nxt_c ^ (idx_nxt_c >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      step_q       <= '0;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hazard_q     <= 1'b0;
      mask_q       <= '0;
      first_step_q <= '0;
      first_chan_q <= '0;
      prev_q       <= '0;
      for (int i = 0; i < int'(LAT); i++) begin
        samp_q[i]      <= '0;
        tag_vld_q[i]   <= 1'b0;
        tag_first_q[i] <= 1'b0;
        tag_step_q[i]  <= '0;
      end
      for (int c = 0; c < int'(C); c++) edge_cnt_q[c] <= 2'd0;
    end else begin
      done_q         <= 1'b0;
      samp_q[0]      <= bus_if.dutOut;
      tag_vld_q[0]   <= (state_q == SCAN);
      tag_first_q[0] <= (hold_q == '0);
      tag_step_q[0]  <= step_q;
      for (int i = 1; i < int'(LAT); i++) begin
        samp_q[i]      <= samp_q[i-1];
        tag_vld_q[i]   <= tag_vld_q[i-1];
        tag_first_q[i] <= tag_first_q[i-1];
        tag_step_q[i]  <= tag_step_q[i-1];
      end
      prev_q <= sample_c;
      for (int c = 0; c < int'(C); c++) edge_cnt_q[c] <= edge_cnt_d[c];

      if (any_hit_c) begin
        mask_q   <= mask_q | hit_c;
        hazard_q <= 1'b1;
        if (!hazard_q) begin
          first_step_q <= tag_step_q[LAT-1];
          first_chan_q <= hit_chan_c;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus_if.start) begin
            state_q      <= SCAN;
            busy_q       <= 1'b1;
            step_q       <= '0;
            hold_q       <= '0;
            dut_in_q     <= '0;
            hazard_q     <= 1'b0;
            mask_q       <= '0;
            first_step_q <= '0;
            first_chan_q <= '0;
            for (int c = 0; c < int'(C); c++) edge_cnt_q[c] <= 2'd0;
          end
        end
        SCAN: begin
          if (hold_q == HW'(HOLD - 1)) begin
            hold_q <= '0;
            if (step_q == SW'(S - 1)) begin
              state_q <= DRAIN;
            end else begin
              step_q   <= step_nxt_c;
              dut_in_q <= code_nxt_c;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        DRAIN: begin
          // Wait for the last window's samples to clear the pipeline.
          if (hold_q == HW'(LAT - 1)) begin
            hold_q  <= '0;
            step_q  <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.dutIn      = dut_in_q;
  assign bus_if.busy       = busy_q;
  assign bus_if.done       = done_q;
  assign bus_if.hazard     = hazard_q;
  assign bus_if.hazardMask = mask_q;
  assign bus_if.firstStep  = first_step_q;
  assign bus_if.firstChan  = first_chan_q;
endmodule

// File: tb/tb_gray_hazard_scanner.sv
// Bench for gray_hazard_scanner: directed glitch scenarios checked against a
// window-counting reference model every cycle, plus literal end-of-scan results.
module tb_gray_hazard_scanner;
  localparam int M  = 3;
  localparam int C  = 4;
  localparam int H  = 8;
  localparam int N  = 8;
  localparam int S  = 15;
  localparam int SW = M + 1;
  localparam int CW = 2;
`ifdef HAZARD_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int SCAN_CYC = S * H;
  localparam int DONE_REL = SCAN_CYC + LAT + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [C-1:0] glitch;

  gray_hazard_scanner_if #(.M(M), .C(C)) bus ();

  gray_hazard_scanner #(.M(M), .C(C), .HOLD(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus.slave)
  );

  always #5 clk = ~clk;

  // Clean block under test: parity, constant 0, bit 0, constant 0; glitch adds pulses.
  always_comb bus.dutOut = {1'b0, bus.dutIn[0], 1'b0, ^bus.dutIn} ^ glitch;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int done_rel_seen = 0;
  int busy_cnt = 0;
  int last_busy = 0;
  bit m_active = 1'b0;
  int m_rel = 0;
  logic [C-1:0]  hist [0:DONE_REL];
  logic [C-1:0]  r_mask = '0;
  logic [SW-1:0] r_fs = '0;
  logic [CW-1:0] r_fc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] walk_code(input int s);
    int k;
    k = (s < N) ? s : 2 * N - 2 - s;
    return M'(k ^ (k >> 1));
  endfunction

  // Results implied by dutOut history up to cycle jmax (1 = first busy cycle).
  task automatic model_eval(input int jmax, output logic [C-1:0] mask,
                            output logic [SW-1:0] fs, output logic [CW-1:0] fc);
    int cnt [C];
    logic [C-1:0] hit;
    mask = '0; fs = '0; fc = '0;
    for (int s = 0; s < S; s++) begin
      for (int c = 0; c < C; c++) cnt[c] = 0;
      for (int j = s * H + 1; j <= s * H + H && j <= jmax; j++) begin
        hit = '0;
        for (int c = 0; c < C; c++) begin
          if (hist[j][c] !== hist[j-1][c]) begin
            cnt[c]++;
            if (cnt[c] == 2) hit[c] = 1'b1;
          end
        end
        if (hit != '0 && mask == '0) begin
          fs = SW'(s);
          for (int c = C - 1; c >= 0; c--) if (hit[c]) fc = CW'(c);
        end
        mask = mask | hit;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [C-1:0]  e_mask;
    logic [SW-1:0] e_fs;
    logic [CW-1:0] e_fc;
    logic          e_busy;
    logic          e_done;
    logic [M-1:0]  e_in;
    e_busy = 1'b0; e_done = 1'b0; e_in = '0;
    e_mask = r_mask; e_fs = r_fs; e_fc = r_fc;
    if (!rst_n) begin
      m_active = 1'b0; busy_cnt = 0;
      r_mask = '0; r_fs = '0; r_fc = '0;
      e_mask = '0; e_fs = '0; e_fc = '0;
    end else if (m_active) begin
      m_rel++;
      hist[m_rel] = bus.dutOut;
      e_busy = (m_rel <= SCAN_CYC + LAT);
      e_done = (m_rel == DONE_REL);
      e_in   = (m_rel <= SCAN_CYC) ? walk_code((m_rel - 1) / H) : '0;
      model_eval(m_rel - LAT - 1, e_mask, e_fs, e_fc);
      if (e_done) begin
        m_active = 1'b0;
        r_mask = e_mask; r_fs = e_fs; r_fc = e_fc;
      end
    end
    chk("cyc busy",       32'(bus.busy),       32'(e_busy));
    chk("cyc done",       32'(bus.done),       32'(e_done));
    chk("cyc dutIn",      32'(bus.dutIn),      32'(e_in));
    chk("cyc hazard",     32'(bus.hazard),     32'(|e_mask));
    chk("cyc hazardMask", 32'(bus.hazardMask), 32'(e_mask));
    chk("cyc firstStep",  32'(bus.firstStep),  32'(e_fs));
    chk("cyc firstChan",  32'(bus.firstChan),  32'(e_fc));
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      else if (busy_cnt != 0) begin last_busy = busy_cnt; busy_cnt = 0; end
      if (bus.done) begin n_done++; done_rel_seen = m_rel; end
      if (!m_active && bus.start) begin
        m_active = 1'b1; m_rel = 0; hist[0] = bus.dutOut;
      end
    end
  end

  // One scan; up to two 1-cycle glitch pulses at scan-relative cycles r0/r1 (0 = unused).
  task automatic run_scan(input int r0, input logic [C-1:0] g0, input int r1,
                          input logic [C-1:0] g1, input bit keep_start, input bit chk_walk);
    logic [M-1:0] walk_tbl [S];
    walk_tbl = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4,
                 3'd5, 3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0};
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) bus.start = 1'b0;
    for (int rel = 1; rel <= DONE_REL; rel++) begin
      glitch = ((rel == r0) ? g0 : '0) | ((rel == r1) ? g1 : '0);
      if (chk_walk && rel <= SCAN_CYC && (rel - 1) % H == 0)
        chk("walk code", 32'(bus.dutIn), 32'(walk_tbl[(rel - 1) / H]));
      @(posedge clk); #1;
    end
    glitch = '0;
    if (keep_start) bus.start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int n0, input logic [C-1:0] mask,
                              input int fs, input int fc);
    chk({tag, " done count"},  32'(n_done - n0),   32'd1);
    chk({tag, " done cycle"},  32'(done_rel_seen), 32'(121 + LAT));
    chk({tag, " hazard"},      32'(bus.hazard),    32'(|mask));
    chk({tag, " hazardMask"},  32'(bus.hazardMask), 32'(mask));
    chk({tag, " firstStep"},   32'(bus.firstStep), 32'(fs));
    chk({tag, " firstChan"},   32'(bus.firstChan), 32'(fc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},       32'(bus.busy),       32'd0);
    chk({tag, " done"},       32'(bus.done),       32'd0);
    chk({tag, " dutIn"},      32'(bus.dutIn),      32'd0);
    chk({tag, " hazard"},     32'(bus.hazard),     32'd0);
    chk({tag, " hazardMask"}, 32'(bus.hazardMask), 32'd0);
    chk({tag, " firstStep"},  32'(bus.firstStep),  32'd0);
    chk({tag, " firstChan"},  32'(bus.firstChan),  32'd0);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!bus.done && k < 300) begin @(posedge clk); #1; k++; end
    chk(name, 32'(k < 300), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    bus.start = 1'b0;
    glitch    = '0;
    #12;
    chk_all_zero("reset");
    #10 rst_n = 1'b1;

    n0 = n_done;
    run_scan(0, '0, 0, '0, 1'b0, 1'b1);
    check_result("clean", n0, 4'b0000, 0, 0);
    chk("clean busy length", 32'(last_busy), 32'(120 + LAT));

    n0 = n_done;
    run_scan(44, 4'b0010, 0, '0, 1'b0, 1'b0);
    check_result("step5 ch1", n0, 4'b0010, 5, 1);

    n0 = n_done;
    run_scan(76, 4'b1100, 100, 4'b0001, 1'b0, 1'b0);
    check_result("multi chan", n0, 4'b1101, 9, 2);

    n0 = n_done;
    run_scan(32, 4'b0010, 0, '0, 1'b0, 1'b0);
    check_result("boundary", n0, 4'b0000, 0, 0);

    n0 = n_done;
    run_scan(36, 4'b0010, 0, '0, 1'b0, 1'b0);
    check_result("step4 double", n0, 4'b0010, 4, 1);

    // Reset at scan cycle 40 after a hazard was already recorded.
    n0 = n_done;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int rel = 1; rel < 40; rel++) begin
      glitch = (rel == 20) ? 4'b0010 : '0;
      @(posedge clk); #1;
    end
    glitch = '0;
    chk("pre-reset hazard", 32'(bus.hazard), 32'd1);
    chk("pre-reset busy",   32'(bus.busy),   32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid-scan reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("reset no done", 32'(n_done - n0), 32'd0);
    n0 = n_done;
    run_scan(0, '0, 0, '0, 1'b0, 1'b0);
    check_result("after reset", n0, 4'b0000, 0, 0);

    // start held through a whole scan: one scan, then a new one right after done.
    n0 = n_done;
    run_scan(0, '0, 0, '0, 1'b1, 1'b0);
    chk("held start one done", 32'(n_done - n0), 32'd1);
    chk("held start rescan busy", 32'(bus.busy), 32'd1);
    wait_done("held start second scan done");
    chk("held start two dones", 32'(n_done - n0), 32'd2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gray_hazard_scanner.md
# gray_hazard_scanner

Clocked, parametrised hazard scanner for combinational blocks under test. It drives an M-bit Gray-code walk to the block under test: ascending through all 2^M codes, then descending back to 0, one bit flip per step. It oversamples C output channels while each code is held and flags any channel whose output toggles more than once within a step. It is the synthesizable, multi-channel successor of the behavioural single-output hazard recognizer and sits between the test sequencer and the combinational block.

## Interface
- M, 3: stimulus width; N = 2^M codes; S = 2N-1 steps per scan.
- C, 1: number of observed output channels.
- HOLD, 8: clock cycles each code is held; legal range 2..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin scan; sampled only in IDLE.
- dutIn  output  M  stimulus code to the block under test.
- dutOut  input  C  block-under-test outputs.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the scan completes.
- hazard  output  1  sticky: any channel hazarded during the scan.
- hazardMask  output  C  sticky per-channel hazard flags.
- firstStep  output  M+1  step index (0..S-1) of the first hazard.
- firstChan  output  max(1,$clog2(C))  lowest-numbered channel hazarding at firstStep.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE, start=1: clear hazard, hazardMask, firstStep and firstChan; set step=0 and busy=1; go to SCAN.
- start is ignored in SCAN and DRAIN.
- Stimulus for step s:
  - s < N: dutIn = g(s).
  - N ≤ s ≤ 2N-2: dutIn = g(2N-2-s).
  - g(k) = k ^ (k>>1).
  - Consecutive codes, including the turnaround g(N-1)→g(N-2), differ in exactly one bit.
- Hold counter runs 0..HOLD-1. On wrap, step increments and dutIn updates. After step S-1 wraps, go to DRAIN.
- DRAIN lasts LAT cycles so the final window closes. Then done pulses, busy drops, and the FSM returns to IDLE.
- Observation window for step s: HOLD consecutive samples, starting LAT cycles after dutIn takes the step-s value.
- Per channel, a saturating 2-bit edge counter is cleared at each window start. It increments when the current sample differs from the previous sample, where the previous sample is allowed to lie in the preceding window.
- The expected single transition caused by a code change counts as 1. A counter reaching 2 within one window is a hazard on that channel (static 1/0 pulse or dynamic multi-toggle).
- On a hazard:
  - hazardMask[c] sets, and hazard = |hazardMask.
  - If no hazard has been recorded yet this scan, latch firstStep=s and firstChan=c.
  - If several channels hazard in the same cycle, the lowest c is latched.
- Results hold until the next accepted start.

## Timing
- Reset values:
  - dutIn=0, busy=0, done=0, hazard=0, hazardMask=0, firstStep=0, firstChan=0.
  - FSM in IDLE; hold counter, step and edge counters = 0.
- Sample pipeline latency:
  - LAT=1 without the synchronizer.
  - LAT=3 with HAZARD_SYNC_EN.
- start high at edge t: busy=1 from t+1.
- Step s occupies dutIn from cycle t+1+s·HOLD.
- done pulses at cycle t+1+S·HOLD+LAT; busy is 0 in that same cycle.
- hazard and hazardMask update one cycle after the offending sample is registered.
- rst_n low mid-scan: all state returns to reset values immediately. No done pulse; no partial results retained.
- A dutOut toggle on the last cycle of a window followed by a toggle on the first cycle of the next window counts as one edge in each window. This is not a hazard.

## Configuration
- HAZARD_SYNC_EN defined:
  - dutOut passes through a 2-flop synchronizer before the sample register, so LAT=3.
  - Use when the block under test is asynchronous to clk.
- HAZARD_SYNC_EN undefined:
  - dutOut is registered once, so LAT=1.
  - Windows and done timing shift accordingly.

## Test plan
- Clean XOR-reduction model, M=3, C=1, HOLD=8, start at t: dutIn walks 0,1,3,2,6,7,5,4,5,7,6,2,3,1,0 → hazard=0; done at t+1+120+LAT; busy high 120+LAT cycles.
- C=2; channel 1 gets a 1-cycle high pulse inside step 5 (steady value 0); channel 0 clean → hazardMask=2'b10, firstStep=5, firstChan=1, hazard=1.
- C=4; pulses on channels 2 and 3 in the same cycle of step 9, plus channel 0 at step 12 → hazardMask=4'b1101, firstStep=9, firstChan=2.
- Output toggles on the last cycle of step 3 and again one cycle later in step 4 → no hazard. Output toggles twice within step 4 → hazard with firstStep=4.
- rst_n low at cycle 40 of a scan → all outputs 0 asynchronously. A new start afterwards completes a full scan and done pulses once.
- start held high throughout a scan → exactly one scan. A new scan begins in the cycle after done, because the FSM is back in IDLE and samples start again.
